// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: state encodings, data width and control levels.
package div_unit_pkg;

    localparam int unsigned RegDataBus = 32;
    localparam logic [RegDataBus-1:0] ZeroWord = '0;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    localparam logic DivStart = 1'b1;
    localparam logic DivStop  = 1'b0;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    typedef enum logic [1:0] {
        DIV_IDLE    = 2'b00,
        DIV_BUSY    = 2'b01,
        DIV_DIVZERO = 2'b10,
        DIV_DONE    = 2'b11
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract, restore on borrow.
module div_step
    import div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = RegDataBus
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             quo_o
);

    logic [WIDTH:0] partial;
    logic [WIDTH:0] diff;

    always_comb begin
        partial = {rem_i, bit_i};
        diff    = partial - {1'b0, divisor_i};
        quo_o   = ~diff[WIDTH];
        // A kept remainder is always below the divisor, so WIDTH bits suffice to store it.
        rem_o   = quo_o ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
    end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU; remainder on hi_o, quotient on lo_o.
// Define DIV_EARLY_OUT_EN to finish in one edge when |dividend| < |divisor|.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = RegDataBus
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             annul_i,
    output logic             busy_o,
    output logic             ready_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;

    logic             dvd_neg, dvs_neg;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic [WIDTH-1:0] step_rem, quo_next, rem_fix, quo_fix;
    logic             step_quo;

    assign dvd_neg = signed_i & dividend_i[WIDTH-1];
    assign dvs_neg = signed_i & divisor_i[WIDTH-1];
    assign dvd_mag = dvd_neg ? -dividend_i : dividend_i;
    assign dvs_mag = dvs_neg ? -divisor_i : divisor_i;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i     (rem_q),
        .divisor_i (dvs_q),
        .bit_i     (dvd_q[WIDTH-1]),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    // dvd_q shifts out dividend bits at the top while quotient bits fill in from the bottom.
    assign quo_next = {dvd_q[WIDTH-2:0], step_quo};
    assign quo_fix  = qneg_q ? -quo_next : quo_next;
    assign rem_fix  = rneg_q ? -step_rem : step_rem;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;

        unique case (state_q)
            DIV_IDLE: begin
                if (start_i == DivStart && !annul_i) begin
                    qneg_d = dvd_neg ^ dvs_neg;
                    rneg_d = dvd_neg;
                    dvs_d  = dvs_mag;
                    rem_d  = '0;
                    cnt_d  = '0;
                    if (divisor_i == '0) begin
                        dvd_d   = dividend_i;
                        state_d = DIV_DIVZERO;
                    end
`ifdef DIV_EARLY_OUT_EN
                    else if (dvd_mag < dvs_mag) begin
                        hi_d    = dividend_i;
                        lo_d    = '0;
                        state_d = DIV_DONE;
                    end
`endif
                    else begin
                        dvd_d   = dvd_mag;
                        state_d = DIV_BUSY;
                    end
                end
            end
            DIV_BUSY: begin
                rem_d = step_rem;
                dvd_d = quo_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntMax) begin
                    hi_d    = rem_fix;
                    lo_d    = quo_fix;
                    state_d = DIV_DONE;
                end
            end
            DIV_DIVZERO: begin
                hi_d    = dvd_q;
                lo_d    = '1;
                state_d = DIV_DONE;
            end
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase

        // A flush abandons the operation and leaves the published result untouched.
        if (annul_i && state_q != DIV_IDLE) begin
            state_d = DIV_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end

    assign busy_o  = (state_q != DIV_IDLE) ? ENABLE : DISABLE;
    assign ready_o = (state_q == DIV_DONE) ? DivResultReady : DivResultNotReady;
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed and random checks of div_unit against a magnitude-based reference with a result queue.
module tb_div_unit;

    localparam int unsigned W = 32;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } res_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start_i = 1'b0;
    logic         signed_i = 1'b0;
    logic         annul_i = 1'b0;
    logic [W-1:0] dividend_i = '0;
    logic [W-1:0] divisor_i = '0;
    logic         busy_o, ready_o;
    logic [W-1:0] hi_o, lo_o;

    res_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    div_unit #(
        .WIDTH (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .signed_i   (signed_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .annul_i    (annul_i),
        .busy_o     (busy_o),
        .ready_o    (ready_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] mag(input logic s, input logic [W-1:0] a);
        return (s && a[W-1]) ? -a : a;
    endfunction

    function automatic res_t model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        res_t         r;
        logic [W-1:0] q, m;
        if (b == '0) begin
            r.hi = a;
            r.lo = '1;
        end else begin
            q    = mag(s, a) / mag(s, b);
            m    = mag(s, a) % mag(s, b);
            r.lo = (s && (a[W-1] ^ b[W-1])) ? -q : q;
            r.hi = (s && a[W-1]) ? -m : m;
        end
        return r;
    endfunction

    function automatic int lat_of(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == '0) return 2;
`ifdef DIV_EARLY_OUT_EN
        if (mag(s, a) < mag(s, b)) return 1;
`endif
        return W + 1;
    endfunction

    // Edge count includes the edge that samples start_i.
    task automatic run_op(input string tag, input logic s, input logic [W-1:0] a,
                          input logic [W-1:0] b);
        int           edges, busy_cnt;
        logic         changed;
        logic [W-1:0] hi0, lo0;
        res_t         exp;
        sb_q.push_back(model(s, a, b));
        hi0     = hi_o;
        lo0     = lo_o;
        changed = 1'b0;
        @(negedge clk);
        start_i = 1'b1; signed_i = s; dividend_i = a; divisor_i = b;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        start_i  = 1'b0;
        busy_cnt = 0;
        while (1) begin
            if (busy_o) busy_cnt++;
            if (ready_o || edges >= 100) break;
            if (hi_o !== hi0 || lo_o !== lo0) changed = 1'b1;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check({tag, ".ready"}, W'(ready_o), 32'd1);
        check({tag, ".lat"}, 32'(edges), 32'(lat_of(s, a, b)));
        check({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(lat_of(s, a, b)));
        check({tag, ".hold"}, W'(changed), 32'd0);
        exp = sb_q.pop_front();
        check({tag, ".hi"}, hi_o, exp.hi);
        check({tag, ".lo"}, lo_o, exp.lo);
        @(negedge clk);
        check({tag, ".ready_drop"}, W'(ready_o), 32'd0);
        check({tag, ".busy_drop"}, W'(busy_o), 32'd0);
    endtask

    initial begin
        logic [W-1:0] hi0, lo0;
        int           edges, pulses;
        res_t         exp;

        // Reset state
        #2;
        check("rst.busy", W'(busy_o), 32'd0);
        check("rst.ready", W'(ready_o), 32'd0);
        check("rst.hi", hi_o, 32'd0);
        check("rst.lo", lo_o, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        run_op("divu_100_7", 1'b0, 32'd100, 32'd7);
        check("divu_100_7.plan_hi", hi_o, 32'd2);
        check("divu_100_7.plan_lo", lo_o, 32'd14);

        run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        check("div_m7_2.plan_lo", lo_o, 32'hFFFF_FFFD);
        check("div_m7_2.plan_hi", hi_o, 32'hFFFF_FFFF);

        run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
        check("div_7_m2.plan_lo", lo_o, 32'hFFFF_FFFD);
        check("div_7_m2.plan_hi", hi_o, 32'd1);

        run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf.plan_lo", lo_o, 32'h8000_0000);
        check("div_ovf.plan_hi", hi_o, 32'd0);

        run_op("divu_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        check("divu_ovf.plan_lo", lo_o, 32'd0);
        check("divu_ovf.plan_hi", hi_o, 32'h8000_0000);

        run_op("divzero", 1'b0, 32'h0000_1234, 32'd0);
        check("divzero.plan_hi", hi_o, 32'h0000_1234);
        check("divzero.plan_lo", lo_o, 32'hFFFF_FFFF);

        // Annul at iteration 10
        hi0 = hi_o;
        lo0 = lo_o;
        @(negedge clk);
        start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd1000; divisor_i = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        repeat (10) @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        annul_i = 1'b0;
        check("annul.busy", W'(busy_o), 32'd0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o) pulses++;
        end
        check("annul.pulses", 32'(pulses), 32'd0);
        check("annul.hi", hi_o, hi0);
        check("annul.lo", lo_o, lo0);

        // Asynchronous reset mid-operation
        @(negedge clk);
        start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd1000; divisor_i = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst.busy", W'(busy_o), 32'd0);
        check("arst.ready", W'(ready_o), 32'd0);
        check("arst.hi", hi_o, 32'd0);
        check("arst.lo", lo_o, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        run_op("divu_9_3", 1'b0, 32'd9, 32'd3);
        check("divu_9_3.plan_lo", lo_o, 32'd3);
        check("divu_9_3.plan_hi", hi_o, 32'd0);

        // start_i held through BUSY with different operands
        sb_q.push_back(model(1'b0, 32'd77, 32'd4));
        @(negedge clk);
        start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd77; divisor_i = 32'd4;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        dividend_i = 32'd50; divisor_i = 32'd5;
        while (!ready_o && edges < 100) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        start_i = 1'b0;
        check("held.ready", W'(ready_o), 32'd1);
        check("held.lat", 32'(edges), 32'(W + 1));
        exp = sb_q.pop_front();
        check("held.hi", hi_o, exp.hi);
        check("held.lo", lo_o, exp.lo);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o) pulses++;
        end
        check("held.extra_pulses", 32'(pulses), 32'd0);
        check("held.hi_keep", hi_o, 32'd1);
        check("held.lo_keep", lo_o, 32'd19);

        // start_i and annul_i together in IDLE
        @(negedge clk);
        start_i = 1'b1; annul_i = 1'b1; dividend_i = 32'd9; divisor_i = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0; annul_i = 1'b0;
        check("start_annul.busy", W'(busy_o), 32'd0);

        run_op("small_3_5", 1'b0, 32'd3, 32'd5);
        check("small_3_5.plan_hi", hi_o, 32'd3);
        check("small_3_5.plan_lo", lo_o, 32'd0);
        run_op("small_m3_5", 1'b1, 32'hFFFF_FFFD, 32'd5);

        for (int i = 0; i < 6; i++) begin
            run_op("rnd", 1'($urandom_range(0, 1)), W'($urandom), W'($urandom));
        end
        run_op("rnd_small", 1'b0, W'($urandom_range(0, 20)), W'($urandom_range(1, 40)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
